// File: rtl/adder_pkg.sv
// Shared definitions for the multicycle adder: FSM state codes and a sizing helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ceiling log2, used to size the chunk index counter.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder built from full adders (two half adders plus an OR each).
// Latency: combinational.
// Backpressure: none.
// Ports: x, y - chunk operands; ci - carry in; s - chunk sum; co - carry out of the chunk;
//        c_msb - carry into the chunk's top bit (used for signed overflow on the last chunk).
module chunk_adder #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    // c[i] is the carry into bit i; c[CHUNK] is the carry out.
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic s1;
        logic c1;
        logic c2;

        half_adder u_ha0 (
            .x (x[i]),
            .y (y[i]),
            .s (s1),
            .c (c1)
        );

        half_adder u_ha1 (
            .x (s1),
            .y (c[i]),
            .s (s[i]),
            .c (c2)
        );

        assign c[i+1] = c1 | c2;
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y - addend bits; s - sum bit; c - carry bit.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/multicycle_adder.sv
// Sequential WIDTH-bit add/subtract, CHUNK bits per clock with the carry held in a register.
// Latency: accepted on edge k, out_valid rises after edge k+WIDTH/CHUNK.
// Backpressure: one operation in flight; in_ready only in IDLE, result held until out_ready.
// Ports: clk/rst (sync, active-high); in_valid/in_ready + a, b, cin, sub (operation in);
//        out_valid/out_ready + sum, cout, ovf (result out).
module multicycle_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    import adder_pkg::*;

    localparam int NCHUNK = (CHUNK < 1) ? 1 : (WIDTH / CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if (CHUNK < 1) begin : g_bad_chunk
        $error("multicycle_adder: CHUNK must be >= 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("multicycle_adder: WIDTH must be a multiple of CHUNK");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    // Current chunk slice and its add result
    logic [31:0]      base;
    logic [CHUNK-1:0] x_c;
    logic [CHUNK-1:0] y_c;
    logic [CHUNK-1:0] s_c;
    logic             co_c;
    logic             cmsb_c;

    // Shifts rather than indexed part-selects keep the slice logic width-clean for any WIDTH/CHUNK.
    always_comb begin
        base = 32'(idx_q) * 32'(CHUNK);
        x_c  = CHUNK'(a_q >> base);
        y_c  = CHUNK'(b_q >> base);
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .x     (x_c),
        .y     (y_c),
        .ci    (carry_q),
        .s     (s_c),
        .co    (co_c),
        .c_msb (cmsb_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1, so b is stored pre-inverted.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d   = (sum_q & ~(CHUNK_MASK << base)) | (WIDTH'(s_c) << base);
                carry_d = co_c;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = co_c;
                    ovf_d   = co_c ^ cmsb_c;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: an 8-bit/2-bit-chunk instance and a 1-bit/1-bit-chunk instance.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_multicycle_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 8-bit instance
    logic       iv8, ir8, cin8, sub8, ov8, or8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;

    // 1-bit instance
    logic       iv1, ir1, cin1, sub1, ov1, or1, cout1, ovf1;
    logic [0:0] a1, b1, sum1;

    int total = 0;
    int bad   = 0;

    multicycle_adder #(.WIDTH(8), .CHUNK(2)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .sub       (sub8),
        .out_valid (ov8),
        .out_ready (or8),
        .sum       (sum8),
        .cout      (cout8),
        .ovf       (ovf8)
    );

    multicycle_adder #(.WIDTH(1), .CHUNK(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .sub       (sub1),
        .out_valid (ov1),
        .out_ready (or1),
        .sum       (sum1),
        .cout      (cout1),
        .ovf       (ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain two's-complement arithmetic. Returns {ovf, cout, sum[7:0]}.
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                        input logic ci, input logic s);
        logic [7:0] bb;
        logic [8:0] t;
        logic       ov;
        bb = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {8'd0, (s ? 1'b1 : ci)};
        // Signed overflow: operands share a sign that the result does not.
        ov = (a[7] == bb[7]) && (t[7] != a[7]);
        return {ov, t[8], t[7:0]};
    endfunction

    // Runs one operation on the 8-bit DUT. Called and returns on a falling edge.
    task automatic do_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic s, input logic [9:0] exp,
                          input int stall);
        int w;
        int lat;
        w = 0;
        while (!ir8 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, ".in_ready"}, 32'(ir8), 32'd1);
        a8 = a; b8 = b; cin8 = ci; sub8 = s; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Scramble operands: only the values at acceptance may matter.
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        cin8 = 1'($urandom); sub8 = 1'($urandom);
        chk({tag, ".busy"}, 32'(ir8), 32'd0);
        lat = 0;
        while (!ov8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd4);
        chk({tag, ".sum"},  32'(sum8),  32'(exp[7:0]));
        chk({tag, ".cout"}, 32'(cout8), 32'(exp[8]));
        chk({tag, ".ovf"},  32'(ovf8),  32'(exp[9]));
        if (stall > 0) begin
            iv8 = 1'b1;
            for (int i = 0; i < stall; i++) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
                @(negedge clk);
                chk({tag, ".hold_vld"},  32'(ov8),   32'd1);
                chk({tag, ".hold_rdy"},  32'(ir8),   32'd0);
                chk({tag, ".hold_sum"},  32'(sum8),  32'(exp[7:0]));
                chk({tag, ".hold_cout"}, 32'(cout8), 32'(exp[8]));
                chk({tag, ".hold_ovf"},  32'(ovf8),  32'(exp[9]));
            end
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        chk({tag, ".released_vld"}, 32'(ov8),  32'd0);
        chk({tag, ".released_rdy"}, 32'(ir8),  32'd1);
        chk({tag, ".kept_sum"},     32'(sum8), 32'(exp[7:0]));
    endtask

    // One full-adder case on the 1-bit DUT.
    task automatic do_op1(input logic a, input logic b, input logic ci);
        int   lat;
        logic [1:0] t;
        logic ov;
        string tag;
        tag = $sformatf("fa_%0d%0d%0d", a, b, ci);
        t  = {1'b0, a} + {1'b0, b} + {1'b0, ci};
        ov = (a == b) && (t[0] != a);
        chk({tag, ".in_ready"}, 32'(ir1), 32'd1);
        a1 = a; b1 = b; cin1 = ci; sub1 = 1'b0; iv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
        lat = 0;
        while (!ov1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat),   32'd1);
        chk({tag, ".sum"},     32'(sum1),  32'(t[0]));
        chk({tag, ".cout"},    32'(cout1), 32'(t[1]));
        chk({tag, ".ovf"},     32'(ovf1),  32'(ov));
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
        chk({tag, ".released_rdy"}, 32'(ir1), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb;
        logic       rc, rs;
        int         w;

        rst = 1'b1;
        iv8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; or8 = 1'b0;
        iv1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0; or1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.in_ready8",  32'(ir8),   32'd1);
        chk("reset.out_valid8", 32'(ov8),   32'd0);
        chk("reset.sum8",       32'(sum8),  32'd0);
        chk("reset.cout8",      32'(cout8), 32'd0);
        chk("reset.ovf8",       32'(ovf8),  32'd0);
        chk("reset.in_ready1",  32'(ir1),   32'd1);
        chk("reset.out_valid1", 32'(ov1),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with hand-computed results {ovf, cout, sum}
        do_op8("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h10}, 0);
        do_op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00}, 0);
        do_op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80}, 0);
        do_op8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE}, 0);
        do_op8("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, {1'b1, 1'b1, 8'h7F}, 0);
        do_op8("add_cin",   8'hFE, 8'h00, 1'b1, 1'b0, {1'b0, 1'b0, 8'hFF}, 0);

        // Result held under backpressure with in_valid asserted
        do_op8("stall", 8'h3C, 8'h55, 1'b1, 1'b0, {1'b1, 1'b0, 8'h92}, 5);

        // Reset in the second RUN cycle aborts the operation
        w = 0;
        while (!ir8 && w < 20) begin
            @(negedge clk);
            w++;
        end
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; sub8 = 1'b0; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort.in_ready",  32'(ir8),   32'd1);
        chk("abort.out_valid", 32'(ov8),   32'd0);
        chk("abort.sum",       32'(sum8),  32'd0);
        chk("abort.cout",      32'(cout8), 32'd0);
        chk("abort.ovf",       32'(ovf8),  32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort.no_result", 32'(ov8), 32'd0);
        end
        do_op8("after_abort", 8'h01, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h02}, 0);

        // Random operations against the arithmetic model
        for (int n = 0; n < 30; n++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            do_op8($sformatf("rand%0d", n), ra, rb, rc, rs, ref8(ra, rb, rc, rs),
                   int'($urandom_range(0, 2)));
        end

        // Single-bit instance: full-adder truth table
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            do_op1(v[2], v[1], v[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
